if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 134 +++++++++++++
 tb/tb_if_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC select and the IF/ID pipeline register.
// Optional macro IF_STAGE_EXC_EN adds exception/eret redirects and AdEL fetch checking.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter int unsigned IM_WORDS   = 4096,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  npc_sel,
  input  logic [31:0] br_target,
  input  logic [31:0] jr_target,
  input  logic [25:0] j_index,
  output logic [31:0] im_addr,
  input  logic [31:0] im_instr,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc8,
`ifdef IF_STAGE_EXC_EN
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic        id_exc,
  output logic [4:0]  id_exccode,
`endif
  output logic        id_valid
);

  logic [31:0] pc_q, pc_d, npc;
  logic [31:0] instr_q, instr_d, ipc_q, ipc_d, ipc8_q, ipc8_d;
  logic        valid_q, valid_d;
  logic        bubble;

`ifdef IF_STAGE_EXC_EN
  // One past the last fetchable byte; 33 bits so the bound cannot wrap.
  localparam logic [32:0] ImEnd = {1'b0, RESET_PC} + 33'(IM_WORDS) * 33'd4;

  logic       exc_q, exc_d;
  logic [4:0] code_q, code_d;
  logic       adel;

  assign adel = (pc_q[1:0] != 2'b00) || (pc_q < RESET_PC) || ({1'b0, pc_q} >= ImEnd);
`endif

  always_comb begin
    case (npc_sel)
      2'b00:   npc = pc_q + 32'd4;
      2'b01:   npc = br_target;
      2'b10:   npc = {ipc_q[31:28], j_index, 2'b00};
      default: npc = jr_target;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    ipc8_d  = ipc8_q;
    valid_d = valid_q;
    bubble  = flush;
`ifdef IF_STAGE_EXC_EN
    exc_d   = exc_q;
    code_d  = code_q;
`endif
    if (!stall) pc_d = npc;
`ifdef IF_STAGE_EXC_EN
    // Exception and eret redirect regardless of stall and squash the fetched slot.
    if (exc_req) begin
      pc_d   = EXC_VECTOR;
      bubble = 1'b1;
    end else if (eret_req) begin
      pc_d   = epc;
      bubble = 1'b1;
    end
`endif
    if (bubble) begin
      instr_d = '0;
      ipc_d   = '0;
      ipc8_d  = '0;
      valid_d = 1'b0;
`ifdef IF_STAGE_EXC_EN
      exc_d   = 1'b0;
      code_d  = '0;
`endif
    end else if (!stall) begin
      instr_d = im_instr;
      ipc_d   = pc_q;
      ipc8_d  = pc_q + 32'd8;
      valid_d = 1'b1;
`ifdef IF_STAGE_EXC_EN
      if (adel) instr_d = '0;
      exc_d  = adel;
      code_d = adel ? 5'd4 : 5'd0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      ipc_q   <= '0;
      ipc8_q  <= '0;
      valid_q <= 1'b0;
`ifdef IF_STAGE_EXC_EN
      exc_q   <= 1'b0;
      code_q  <= '0;
`endif
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ipc8_q  <= ipc8_d;
      valid_q <= valid_d;
`ifdef IF_STAGE_EXC_EN
      exc_q   <= exc_d;
      code_q  <= code_d;
`endif
    end
  end

  assign im_addr  = pc_q;
  assign id_instr = instr_q;
  assign id_pc    = ipc_q;
  assign id_pc8   = ipc8_q;
  assign id_valid = valid_q;
`ifdef IF_STAGE_EXC_EN
  assign id_exc     = exc_q;
  assign id_exccode = code_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a cycle-level reference model checked every cycle plus
// hand-computed literal checkpoints. Honors IF_STAGE_EXC_EN when defined.
module tb_if_stage;

  localparam logic [31:0] RST = 32'h0000_3000;
  localparam longint unsigned ImBytes = 64'd4 * 64'd4096;

  logic        clk = 1'b0;
  logic        reset = 1'b1, stall = 1'b0, flush = 1'b0;
  logic [1:0]  npc_sel = 2'b00;
  logic [31:0] br_target = '0, jr_target = '0;
  logic [25:0] j_index = '0;
  logic [31:0] im_addr, im_instr, id_instr, id_pc, id_pc8;
  logic        id_valid;
`ifdef IF_STAGE_EXC_EN
  logic        exc_req = 1'b0, eret_req = 1'b0;
  logic [31:0] epc = '0;
  logic        id_exc;
  logic [4:0]  id_exccode;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Instruction memory stand-in: every address reads back its bitwise inverse.
  assign im_instr = ~im_addr;

  if_stage #(.RESET_PC(RST), .IM_WORDS(4096), .EXC_VECTOR(32'h0000_4180)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .npc_sel(npc_sel),
    .br_target(br_target), .jr_target(jr_target), .j_index(j_index),
    .im_addr(im_addr), .im_instr(im_instr), .id_instr(id_instr), .id_pc(id_pc),
    .id_pc8(id_pc8),
`ifdef IF_STAGE_EXC_EN
    .exc_req(exc_req), .eret_req(eret_req), .epc(epc), .id_exc(id_exc),
    .id_exccode(id_exccode),
`endif
    .id_valid(id_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: what the architectural state must be after each edge.
  logic [31:0] m_pc, m_instr, m_ipc, m_ipc8;
  logic        m_valid, m_exc, m_ok = 1'b0;
  logic [4:0]  m_code;

  function automatic logic [31:0] wrap(input longint unsigned v);
    return v[31:0];
  endfunction

  function automatic logic [31:0] redirect(input logic [31:0] pc, input logic [31:0] ipc);
    case (npc_sel)
      2'b00:   return wrap(longint'(pc) + 4);
      2'b01:   return br_target;
      2'b10:   return (ipc & 32'hF000_0000) | (32'(j_index) * 4);
      default: return jr_target;
    endcase
  endfunction

  function automatic logic bad_fetch(input logic [31:0] pc);
`ifdef IF_STAGE_EXC_EN
    return (pc % 4 != 0) || (pc < RST) || (longint'(pc) >= longint'(RST) + ImBytes);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    logic kill, hold;
    kill = flush;
    hold = stall;
    if (reset) begin
      m_ok <= 1'b1;
      m_pc <= RST;
      m_instr <= 0; m_ipc <= 0; m_ipc8 <= 0; m_valid <= 0; m_exc <= 0; m_code <= 0;
    end else begin
`ifdef IF_STAGE_EXC_EN
      if (exc_req || eret_req) begin
        kill = 1'b1;
        hold = 1'b1;
        m_pc <= exc_req ? 32'h0000_4180 : epc;
      end
`endif
      if (!hold) m_pc <= redirect(m_pc, m_ipc);
      if (kill) begin
        m_instr <= 0; m_ipc <= 0; m_ipc8 <= 0; m_valid <= 0; m_exc <= 0; m_code <= 0;
      end else if (!stall) begin
        m_instr <= bad_fetch(m_pc) ? 32'h0 : ~m_pc;
        m_ipc   <= m_pc;
        m_ipc8  <= wrap(longint'(m_pc) + 8);
        m_valid <= 1'b1;
        m_exc   <= bad_fetch(m_pc);
        m_code  <= bad_fetch(m_pc) ? 5'd4 : 5'd0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("im_addr", im_addr, m_pc);
      chk("id_instr", id_instr, m_instr);
      chk("id_pc", id_pc, m_ipc);
      chk("id_pc8", id_pc8, m_ipc8);
      chk("id_valid", 32'(id_valid), 32'(m_valid));
`ifdef IF_STAGE_EXC_EN
      chk("id_exc", 32'(id_exc), 32'(m_exc));
      chk("id_exccode", 32'(id_exccode), 32'(m_code));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset while stalled with a pending branch.
    reset = 1; stall = 1; npc_sel = 2'b01; br_target = 32'h1234_5678;
    step(); step();
    chk("rst_pc", im_addr, 32'h0000_3000);
    chk("rst_instr", id_instr, 32'h0);
    chk("rst_pc8", id_pc8, 32'h0);
    chk("rst_valid", 32'(id_valid), 32'h0);
    reset = 0; stall = 0; npc_sel = 2'b00;

    step();
    chk("seq1_pc", im_addr, 32'h0000_3004);
    chk("seq1_instr", id_instr, 32'hFFFF_CFFF);
    chk("seq1_idpc", id_pc, 32'h0000_3000);
    step();
    chk("seq2_pc", im_addr, 32'h0000_3008);
    step();
    chk("seq3_pc", im_addr, 32'h0000_300C);
    chk("seq3_pc8", id_pc8, 32'h0000_3010);

    // Back to 3008, then stall two cycles there.
    npc_sel = 2'b11; jr_target = 32'h0000_3008;
    step();
    npc_sel = 2'b00; stall = 1;
    step(); step();
    chk("stall_pc", im_addr, 32'h0000_3008);
    chk("stall_idpc", id_pc, 32'h0000_300C);
    stall = 0;
    step();
    chk("release_pc", im_addr, 32'h0000_300C);
    chk("release_idpc", id_pc, 32'h0000_3008);

    step(); step();
    chk("pre_jump_idpc", id_pc, 32'h0000_3010);
    npc_sel = 2'b10; j_index = 26'h0C40; flush = 1;
    step();
    chk("jump_pc", im_addr, 32'h0000_3100);
    chk("jump_flush_valid", 32'(id_valid), 32'h0);

    flush = 0; npc_sel = 2'b01; br_target = 32'h0000_3200;
    step();
    chk("branch_pc", im_addr, 32'h0000_3200);
    chk("branch_idpc", id_pc, 32'h0000_3100);

    // Stall plus flush: PC held, bubble loaded.
    stall = 1; flush = 1; npc_sel = 2'b00;
    step();
    chk("stallflush_pc", im_addr, 32'h0000_3200);
    chk("stallflush_valid", 32'(id_valid), 32'h0);
    stall = 0; flush = 0;

    npc_sel = 2'b11; jr_target = 32'hFFFF_FFFC;
    step();
    chk("jr_top_pc", im_addr, 32'hFFFF_FFFC);
    npc_sel = 2'b00;
    step();
    chk("wrap_pc", im_addr, 32'h0000_0000);
    chk("wrap_pc8", id_pc8, 32'h0000_0004);
    step();

    // Reset mid-stall with a redirect pending.
    stall = 1; npc_sel = 2'b01; br_target = 32'h0000_5000; reset = 1;
    step();
    chk("rst2_pc", im_addr, 32'h0000_3000);
    chk("rst2_idpc", id_pc, 32'h0);
    reset = 0; stall = 0; npc_sel = 2'b00;
    step();
    chk("rst2_next_pc", im_addr, 32'h0000_3004);

`ifdef IF_STAGE_EXC_EN
    npc_sel = 2'b11; jr_target = 32'h0000_3001;
    step();
    npc_sel = 2'b00;
    step();
    chk("adel_exc", 32'(id_exc), 32'h1);
    chk("adel_code", 32'(id_exccode), 32'h4);
    chk("adel_instr", id_instr, 32'h0);
    exc_req = 1; stall = 1;
    step();
    chk("exc_pc", im_addr, 32'h0000_4180);
    chk("exc_valid", 32'(id_valid), 32'h0);
    exc_req = 0; stall = 0; eret_req = 1; epc = 32'h0000_3020;
    step();
    chk("eret_pc", im_addr, 32'h0000_3020);
    eret_req = 0;
    step();
    chk("post_eret_exc", 32'(id_exc), 32'h0);
`endif

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
